// File: rtl/ip4_sm_bk_ctl_pkg.sv
// +----------------------------------------------------------------------+
// | ip4_sm_bk_ctl_pkg : shared types for the shared-memory bank control  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ip4_sm_bk_ctl_pkg;

  localparam int SM_ADR_W  = 10;
  localparam int SM_DAT_W  = 32;
  localparam int SM_TAG_W  = 4;
  localparam int SM_RD_LAT = 1;

  typedef logic [SM_ADR_W-1:0] smadr_t;
  typedef logic [SM_DAT_W-1:0] word;

  typedef struct packed {
    logic                we;
    smadr_t              adr;
    word                 dat;
    logic [SM_TAG_W-1:0] tag;
  } sm_req_t;

  typedef struct packed {
    logic                port;
    logic [SM_TAG_W-1:0] tag;
    word                 dat;
  } sm_rsp_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sm_ctl_st_e;

  // With a single requester its own index wins; on conflict the pointer decides.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ip4_sm_bk_ctl_if.sv
// +----------------------------------------------------------------------+
// | ip4_sm_bk_ctl_if : client request / bank port / response bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface ip4_sm_bk_ctl_if #(
  parameter int ADR_W = 10,
  parameter int DAT_W = 32,
  parameter int TAG_W = 4
);
  logic [1:0]       req_vld;
  logic [1:0]       req_rdy;
  logic [1:0]       req_we;
  logic [ADR_W-1:0] req_adr [2];
  logic [DAT_W-1:0] req_dat [2];
  logic [TAG_W-1:0] req_tag [2];

  logic             bk_wen;
  logic [ADR_W-1:0] bk_adr;
  logic [DAT_W-1:0] bk_datai;
  logic [DAT_W-1:0] bk_datao;

  logic             rsp_vld;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [DAT_W-1:0] rsp_dat;
  logic             init_done;

  modport master (
    output req_vld, req_we, req_adr, req_dat, req_tag, bk_datao,
    input  req_rdy, bk_wen, bk_adr, bk_datai,
    input  rsp_vld, rsp_port, rsp_tag, rsp_dat, init_done
  );

  modport slave (
    input  req_vld, req_we, req_adr, req_dat, req_tag, bk_datao,
    output req_rdy, bk_wen, bk_adr, bk_datai,
    output rsp_vld, rsp_port, rsp_tag, rsp_dat, init_done
  );
endinterface

`default_nettype wire

// File: rtl/ip4_sm_bk_ctl_arb.sv
// +----------------------------------------------------------------------+
// | ip4_rr_arb2 : two-way round-robin arbiter with pointer register      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ip4_rr_arb2
  import ip4_sm_bk_ctl_pkg::*;
(
  input  wire        clk,
  input  wire        rst_n,
  input  wire        en,
  input  wire  [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;
  logic w_pick;

  assign w_pick = rr_pick(req, ptr_q);

  // The pointer names the client that wins the next conflict.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en && (req != 2'b00)) begin
      gnt[w_pick] = 1'b1;
      ptr_d       = ~w_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ip4_sm_bk_ctl.sv
// +----------------------------------------------------------------------+
// | ip4_sm_bk_ctl : bank clear, 2-client arbitration, tagged read return |
// | Optional perf counters: IP4_SM_BK_PERF_EN            Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module ip4_sm_bk_ctl
  import ip4_sm_bk_ctl_pkg::*;
#(
  parameter int ADR_W  = SM_ADR_W,
  parameter int DAT_W  = SM_DAT_W,
  parameter int TAG_W  = SM_TAG_W,
  parameter int RD_LAT = SM_RD_LAT
) (
  input wire             clk,
  input wire             rst_n,
  ip4_sm_bk_ctl_if.slave bus
`ifdef IP4_SM_BK_PERF_EN
  ,
  output logic [31:0]    perf_acc,
  output logic [31:0]    perf_cfl
`endif
);

  sm_ctl_st_e        st_q, st_d;
  logic [ADR_W-1:0]  cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              bk_wen_q, bk_wen_d;
  logic [ADR_W-1:0]  bk_adr_q, bk_adr_d;
  logic [DAT_W-1:0]  bk_datai_q, bk_datai_d;
  logic [RD_LAT-1:0] pvld_q, pvld_d;
  logic [TAG_W:0]    pipe_q [RD_LAT];
  logic [TAG_W:0]    pipe_d [RD_LAT];
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_port_q, rsp_port_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

  logic [1:0]        w_gnt;
  logic              w_acc;
  logic              w_sel;

  // Requests are only granted once the clear sweep has been reported done.
  ip4_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (init_done_q),
    .req   (bus.req_vld),
    .gnt   (w_gnt)
  );

  assign w_acc = |w_gnt;
  assign w_sel = w_gnt[1];

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    bk_wen_d    = 1'b0;
    bk_adr_d    = bk_adr_q;
    bk_datai_d  = bk_datai_q;
    case (st_q)
      INIT: begin
        bk_wen_d   = 1'b1;
        bk_adr_d   = cnt_q;
        bk_datai_d = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          st_d = RUN;
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        if (w_acc) begin
          bk_wen_d   = bus.req_we[w_sel];
          bk_adr_d   = bus.req_adr[w_sel];
          bk_datai_d = bus.req_dat[w_sel];
        end
      end
      default: st_d = INIT;
    endcase

    // {port, tag} of each accepted read rides along with the bank latency.
    pvld_d[0] = w_acc & ~bus.req_we[w_sel];
    pipe_d[0] = {w_sel, bus.req_tag[w_sel]};
    for (int i = 1; i < RD_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pipe_d[i] = pipe_q[i-1];
    end
    rsp_vld_d  = pvld_q[RD_LAT-1];
    rsp_port_d = pvld_q[RD_LAT-1] ? pipe_q[RD_LAT-1][TAG_W]     : 1'b0;
    rsp_tag_d  = pvld_q[RD_LAT-1] ? pipe_q[RD_LAT-1][TAG_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      bk_wen_q    <= 1'b0;
      bk_adr_q    <= '0;
      bk_datai_q  <= '0;
      pvld_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      rsp_vld_q   <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      bk_wen_q    <= bk_wen_d;
      bk_adr_q    <= bk_adr_d;
      bk_datai_q  <= bk_datai_d;
      pvld_q      <= pvld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      rsp_vld_q   <= rsp_vld_d;
      rsp_port_q  <= rsp_port_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign bus.req_rdy   = w_gnt;
  assign bus.bk_wen    = bk_wen_q;
  assign bus.bk_adr    = bk_adr_q;
  assign bus.bk_datai  = bk_datai_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_tag   = rsp_tag_q;
  // The bank delivers the data in the very cycle the response is flagged.
  assign bus.rsp_dat   = rsp_vld_q ? bus.bk_datao : '0;
  assign bus.init_done = init_done_q;

`ifdef IP4_SM_BK_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d;
  logic [31:0] perf_cfl_q, perf_cfl_d;

  always_comb begin
    perf_acc_d = perf_acc_q;
    perf_cfl_d = perf_cfl_q;
    if (w_acc && (perf_acc_q != '1)) begin
      perf_acc_d = perf_acc_q + 32'd1;
    end
    if (init_done_q && (&bus.req_vld) && (perf_cfl_q != '1)) begin
      perf_cfl_d = perf_cfl_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_acc_q <= '0;
      perf_cfl_q <= '0;
    end else begin
      perf_acc_q <= perf_acc_d;
      perf_cfl_q <= perf_cfl_d;
    end
  end

  assign perf_acc = perf_acc_q;
  assign perf_cfl = perf_cfl_q;
`else
  // Build without access/conflict counters.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ip4_sm_bk_ctl.sv
// +----------------------------------------------------------------------+
// | tb_ip4_sm_bk_ctl : bench for ip4_sm_bk_ctl with a bank model         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ip4_sm_bk_ctl;
  import ip4_sm_bk_ctl_pkg::*;

  localparam int ADR_W  = 4;
  localparam int DAT_W  = 32;
  localparam int TAG_W  = 4;
  localparam int RD_LAT = SM_RD_LAT;
  localparam int DEPTH  = 1 << ADR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ip4_sm_bk_ctl_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TAG_W(TAG_W)) bus ();

`ifdef IP4_SM_BK_PERF_EN
  logic [31:0] perf_acc;
  logic [31:0] perf_cfl;
`endif

  ip4_sm_bk_ctl #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef IP4_SM_BK_PERF_EN
    ,
    .perf_acc (perf_acc),
    .perf_cfl (perf_cfl)
`endif
  );

  // Bank: registered read, RD_LAT cycles from address to data.
  logic [DAT_W-1:0] bank_mem [DEPTH];
  logic [DAT_W-1:0] bank_rd  [RD_LAT];
  always @(posedge clk) begin
    if (bus.bk_wen) bank_mem[bus.bk_adr] <= bus.bk_datai;
    bank_rd[0] <= bank_mem[bus.bk_adr];
    for (int i = 1; i < RD_LAT; i++) bank_rd[i] <= bank_rd[i-1];
  end
  assign bus.bk_datao = bank_rd[RD_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               due;
    int               port;
    int               tag;
    logic [DAT_W-1:0] dat;
  } rsp_t;

  int               k = 0;
  bit               armed = 0;
  int               prefer = 0;
  logic [DAT_W-1:0] mmem [DEPTH];
  bit               pend_v = 0;
  logic             pend_we;
  logic [ADR_W-1:0] pend_adr;
  logic [DAT_W-1:0] pend_dat;
  rsp_t             rq[$];
  int               m_acc = 0;
  int               m_cfl = 0;

  always @(negedge clk) begin
    logic [1:0] erdy;
    logic [1:0] v;
    int         g;
    rsp_t       e;
    v    = bus.req_vld;
    erdy = 2'b00;
    g    = -1;
    if (k > DEPTH && v != 2'b00) begin
      g = (v == 2'b11) ? prefer : (v[1] ? 1 : 0);
      erdy[g] = 1'b1;
    end
    if (armed) begin
      if (k == 0) begin
        chk("rst_rdy", bus.req_rdy, 0);
        chk("rst_wen", bus.bk_wen, 0);
        chk("rst_adr", bus.bk_adr, 0);
        chk("rst_datai", bus.bk_datai, 0);
        chk("rst_rsp_vld", bus.rsp_vld, 0);
        chk("rst_rsp_port", bus.rsp_port, 0);
        chk("rst_rsp_tag", bus.rsp_tag, 0);
        chk("rst_rsp_dat", bus.rsp_dat, 0);
        chk("rst_init_done", bus.init_done, 0);
      end else if (k <= DEPTH) begin
        chk("init_rdy", bus.req_rdy, 0);
        chk("init_wen", bus.bk_wen, 1);
        chk("init_adr", bus.bk_adr, k - 1);
        chk("init_datai", bus.bk_datai, 0);
        chk("init_done_lo", bus.init_done, 0);
        chk("init_rsp_vld", bus.rsp_vld, 0);
      end else begin
        chk("run_init_done", bus.init_done, 1);
        chk("run_wen", bus.bk_wen, pend_v && pend_we);
        if (pend_v) begin
          chk("run_adr", bus.bk_adr, pend_adr);
          if (pend_we) chk("run_datai", bus.bk_datai, pend_dat);
        end
        if (rq.size() > 0 && rq[0].due == k) begin
          e = rq.pop_front();
          chk("rsp_vld", bus.rsp_vld, 1);
          chk("rsp_port", bus.rsp_port, e.port);
          chk("rsp_tag", bus.rsp_tag, e.tag);
          chk("rsp_dat", bus.rsp_dat, e.dat);
        end else begin
          chk("rsp_idle", bus.rsp_vld, 0);
        end
        chk("run_rdy", bus.req_rdy, erdy);
      end
`ifdef IP4_SM_BK_PERF_EN
      chk("perf_acc", perf_acc, m_acc);
      chk("perf_cfl", perf_cfl, m_cfl);
`endif
    end
    // advance the model to the next cycle
    if (!rst_n) begin
      armed  = 1;
      k      = 0;
      prefer = 0;
      pend_v = 0;
      rq.delete();
      m_acc  = 0;
      m_cfl  = 0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    end else if (armed) begin
      pend_v = 0;
      if (k > DEPTH) begin
        if (v == 2'b11) m_cfl++;
        if (g >= 0) begin
          m_acc++;
          prefer   = 1 - g;
          pend_v   = 1;
          pend_we  = bus.req_we[g];
          pend_adr = bus.req_adr[g];
          pend_dat = bus.req_dat[g];
          if (pend_we) begin
            mmem[pend_adr] = pend_dat;
          end else begin
            e.due  = k + RD_LAT + 1;
            e.port = g;
            e.tag  = int'(bus.req_tag[g]);
            e.dat  = mmem[pend_adr];
            rq.push_back(e);
          end
        end
      end
      k++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [ADR_W-1:0] adr,
                         input logic [DAT_W-1:0] dat, input logic [TAG_W-1:0] tag);
    bus.req_vld[p] = 1'b1;
    bus.req_we[p]  = we;
    bus.req_adr[p] = adr;
    bus.req_dat[p] = dat;
    bus.req_tag[p] = tag;
  endtask

  task automatic wait_init();
    int n = 0;
    while (bus.init_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("init_done_timeout", bus.init_done, 1);
  endtask

  int               alt_seq [6];
  int               exp_alt [6] = '{0, 1, 0, 1, 0, 1};
  int               rsp_cyc [$];
  int               rsp_tg  [$];
  logic [DAT_W-1:0] rsp_dt  [$];

  initial begin
    bus.req_vld = 2'b00;
    bus.req_we  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      bus.req_adr[p] = '0;
      bus.req_dat[p] = '0;
      bus.req_tag[p] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    // clear sweep: 16 writes of 0 to addresses 0..15, then init_done
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      chk("sweep_wen", bus.bk_wen, 1);
      chk("sweep_adr", bus.bk_adr, c - 1);
    end
    chk("sweep_done_lo", bus.init_done, 0);
    tick();
    chk("sweep_done_hi", bus.init_done, 1);

    // both clients hold valid for 6 cycles
    set_req(0, 1'b1, 4'h8, 32'h1234_5678, 4'h0);
    set_req(1, 1'b0, 4'h9, 32'h0, 4'h1);
    for (int i = 0; i < 6; i++) begin
      #1;
      alt_seq[i] = (bus.req_rdy == 2'b01) ? 0 : (bus.req_rdy == 2'b10) ? 1 : 9;
      tick();
    end
    bus.req_vld = 2'b00;
    for (int i = 0; i < 6; i++) chk("alt_grant", alt_seq[i], exp_alt[i]);
    repeat (4) tick();

    // client 1 back-to-back reads of 0..7
    for (int i = 0; i < 12; i++) begin
      if (i < 8) set_req(1, 1'b0, 4'(i), 32'h0, 4'(i));
      else bus.req_vld = 2'b00;
      #1;
      if (bus.rsp_vld === 1'b1) begin
        rsp_cyc.push_back(i);
        rsp_tg.push_back(int'(bus.rsp_tag));
        rsp_dt.push_back(bus.rsp_dat);
      end
      tick();
    end
    chk("b2b_count", rsp_cyc.size(), 8);
    if (rsp_cyc.size() == 8) begin
      chk("b2b_first", rsp_cyc[0], 2);
      chk("b2b_last", rsp_cyc[7], 9);
      for (int j = 0; j < 8; j++) begin
        chk("b2b_tag", rsp_tg[j], j);
        chk("b2b_dat", rsp_dt[j], 0);
      end
    end
    repeat (2) tick();

    // write then read the same address from client 0
    set_req(0, 1'b1, 4'h5, 32'hDEAD_BEEF, 4'h0);
    #1;
    chk("wr_rdy", bus.req_rdy, 2'b01);
    tick();
    set_req(0, 1'b0, 4'h5, 32'h0, 4'h3);
    #1;
    chk("rd_rdy", bus.req_rdy, 2'b01);
    tick();
    bus.req_vld = 2'b00;
    chk("rd_rsp_early", bus.rsp_vld, 0);
    tick();
    chk("rd_rsp_vld", bus.rsp_vld, 1);
    chk("rd_rsp_dat", bus.rsp_dat, 32'hDEAD_BEEF);
    chk("rd_rsp_tag", bus.rsp_tag, 3);
    chk("rd_rsp_port", bus.rsp_port, 0);
    repeat (2) tick();

    // reset with two reads in flight
    set_req(0, 1'b0, 4'h1, 32'h0, 4'h5);
    tick();
    set_req(0, 1'b0, 4'h2, 32'h0, 4'h6);
    rst_n = 1'b0;
    tick();
    bus.req_vld = 2'b00;
    chk("drop_rsp0", bus.rsp_vld, 0);
    tick();
    chk("drop_rsp1", bus.rsp_vld, 0);
    rst_n = 1'b1;
    tick();
    chk("resweep_wen", bus.bk_wen, 1);
    chk("resweep_adr", bus.bk_adr, 0);
    chk("drop_rsp2", bus.rsp_vld, 0);
    wait_init();

`ifdef IP4_SM_BK_PERF_EN
    // 4 conflict cycles then 6 single-client cycles: 10 accepts
    set_req(0, 1'b0, 4'h3, 32'h0, 4'h0);
    set_req(1, 1'b0, 4'h4, 32'h0, 4'h1);
    repeat (4) tick();
    bus.req_vld[1] = 1'b0;
    repeat (6) tick();
    bus.req_vld = 2'b00;
    chk("perf_acc_total", perf_acc, 10);
    chk("perf_cfl_total", perf_cfl, 4);
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
